// File: rtl/mips_pipeline_pkg.sv
// rtl/mips_pipeline_pkg.sv - shared types and constants for the MIPS32 fetch pipeline
package mips_pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_4;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_stage_fetch_queue.sv
// rtl/instruction_fetch_stage_fetch_queue.sv - 2-entry fetch FIFO with push, pop and flush
module fetch_queue
    import mips_pipeline_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - MIPS32 IF stage: PC, instruction-memory requests, fetch queue
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pipeline_pkg::NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        IF_ID_pipeline_stall,
    input  logic        Branch_Taken_ID,
    input  logic [31:0] Branch_Target_ID,
    input  logic        Jump_ID,
    input  logic [31:0] Jump_Target_ID,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ready,
    input  logic [31:0] Imem_Data,
    output logic [31:0] Instruction_IF,
    output logic [31:0] PC_Plus_4_IF,
    output logic        Instruction_Valid_IF
);

    import mips_pipeline_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;

    logic         redirect;
    logic [31:0]  target;
    logic         pop;
    logic         push;
    logic         issue_ok;
    logic [1:0]   count;
    logic [1:0]   count_after;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    assign redirect = (Jump_ID || Branch_Taken_ID) && !IF_ID_pipeline_stall;
    assign target   = Jump_ID ? Jump_Target_ID : Branch_Target_ID;
    assign pop      = (count != 2'd0) && !IF_ID_pipeline_stall && !redirect;
    assign push     = (state_q == BUSY) && Imem_Ready && !redirect;

    assign push_entry.instr     = Imem_Data;
    assign push_entry.pc_plus_4 = addr_q + 32'd4;

    // Occupancy after this cycle's push/pop decides whether another word can be requested.
    assign count_after = count + {1'b0, push} - {1'b0, pop};
    assign issue_ok    = (count_after <= 2'd1);

    fetch_queue u_fetch_queue (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .count      (count)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = target;
                end else if (issue_ok) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    pc_d    = pc_q + 32'd4;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (redirect) begin
                    pc_d = target;
                    if (Imem_Ready) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = SQUASH;
                    end
                end else if (Imem_Ready) begin
                    if (issue_ok) begin
                        addr_d = pc_q;
                        pc_d   = pc_q + 32'd4;
                    end else begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            SQUASH: begin
                // The in-flight word belongs to the wrong path; wait it out and drop it.
                if (redirect) begin
                    pc_d = target;
                end
                if (Imem_Ready) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign Imem_Req  = req_q;
    assign Imem_Addr = addr_q;

    always_comb begin
        Instruction_Valid_IF = (count != 2'd0) && !redirect;
        Instruction_IF       = NOP_INSTR;
        PC_Plus_4_IF         = 32'd0;
        if (Instruction_Valid_IF) begin
            Instruction_IF = head.instr;
            PC_Plus_4_IF   = head.pc_plus_4;
        end
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

IF stage of the 5-stage MIPS32 pipeline, directly upstream of `IF_ID_Pipeline_Stage`. It owns the PC and issues instruction-memory requests over a request/ready interface, buffering returned words in a 2-entry fetch queue. It presents `Instruction_IF` and `PC_Plus_4_IF` to the IF/ID register and honours the same `IF_ID_pipeline_stall`. Branch and jump redirects resolved in ID flush wrong-path fetches; there is no delay slot.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `NOP_INSTR`, default `32'h0000_0000`: bubble word (`sll $0,$0,0`).

- `Clk` in 1: rising-edge clock.
- `Reset_n` in 1: reset; one clock, asynchronous, active-low.
- `IF_ID_pipeline_stall` in 1: IF/ID hold; when 1, the head is not consumed and redirects are ignored.
- `Branch_Taken_ID` in 1: taken branch resolved in ID.
- `Branch_Target_ID` in 32: branch target.
- `Jump_ID` in 1: jump in ID; has priority over the branch.
- `Jump_Target_ID` in 32: jump target.
- `Imem_Req` out 1: registered fetch request.
- `Imem_Addr` out 32: registered fetch address.
- `Imem_Ready` in 1: transfer completes on a cycle with `Imem_Req && Imem_Ready`.
- `Imem_Data` in 32: instruction word, valid when `Imem_Ready` is 1.
- `Instruction_IF` out 32: queue head, or `NOP_INSTR`.
- `PC_Plus_4_IF` out 32: head address + 4, or 0 when no valid head.
- `Instruction_Valid_IF` out 1: head is valid and not squashed.

## Operation
- Redirect `R = (Jump_ID || Branch_Taken_ID) && !IF_ID_pipeline_stall`.
- Redirect target `T = Jump_ID ? Jump_Target_ID : Branch_Target_ID`.
- Pop: `count > 0 && !IF_ID_pipeline_stall && !R`.
- Output rule: when `count > 0 && !R`, drive the head with `Instruction_Valid_IF = 1`. Otherwise drive `NOP_INSTR`, 0 and 0.
- Request rule: once `Imem_Req` is high, it and `Imem_Addr` stay constant until `Imem_Ready`. At most one request is outstanding.
- Issue is allowed when the queue count after this cycle's push and pop is ≤ 1.
- FSM states and transitions:
  - **IDLE** (no request outstanding):
    - On `R`: `PC <= T`; no issue this cycle.
    - Otherwise, if issue is allowed: `Imem_Req <= 1`, `Imem_Addr <= PC`, `PC <= PC+4`, go to BUSY.
  - **BUSY**, `Imem_Ready` with no `R`: push `{Imem_Data, Imem_Addr+4}`.
    - If issue is allowed: issue back-to-back and stay in BUSY.
    - Otherwise: `Imem_Req <= 0`, go to IDLE.
  - **BUSY**, `Imem_Ready` with `R`: discard the data, flush the queue, `PC <= T`, `Imem_Req <= 0`, go to IDLE.
  - **BUSY**, no `Imem_Ready`, with `R`: flush the queue, `PC <= T`, go to SQUASH (request stays asserted).
  - **SQUASH**:
    - On `Imem_Ready`: discard the data, `Imem_Req <= 0`, go to IDLE.
    - `R` in SQUASH updates `PC <= T` again.
- Queue behaviour:
  - Push and pop in the same cycle are both performed.
  - Push never targets a full queue; this is guaranteed by the issue rule.
  - Flush sets `count <= 0`.
- PC arithmetic is modulo 2^32; `32'hFFFF_FFFC + 4` wraps to 0.
- Target addresses are used as given; there is no alignment check.

## Timing
- Reset values: PC = `RESET_PC`, state IDLE, count 0, `Imem_Req` 0, `Imem_Addr` = `RESET_PC`.
- Outputs during reset: `Instruction_IF` = `NOP_INSTR`, `PC_Plus_4_IF` 0, `Instruction_Valid_IF` 0.
- Reset asserted mid-transfer drops `Imem_Req` immediately. The memory must tolerate an abandoned request on reset.
- First edge after `Reset_n` rises: `Imem_Req` = 1, `Imem_Addr` = `RESET_PC`.
- Zero-wait memory: head is valid after the 2nd edge; IF/ID captures it at the 3rd edge. Steady state is 1 instruction per cycle.
- Queue full under stall: no issue. Issue resumes in the cycle after the first pop.
- Redirect latency: the cycle with `R` shows a bubble. The target is requested at the next edge, or 1 edge after `Imem_Ready` if the redirect went through SQUASH.

## Structure
- Shared package `mips_pipeline_pkg`:
  - `NOP_INSTR` constant.
  - FSM state enum `{IDLE, BUSY, SQUASH}`.
  - `fetch_entry_t` = `{instr[31:0], pc_plus_4[31:0]}`.
- One sub-module, `fetch_queue`: a 2-entry FIFO with push, pop and flush, exposing head and a 2-bit count. Everything else stays in `instruction_fetch_stage`.

## Test plan
- Reset, then `Imem_Ready` = 1 constantly, data = address: `Instruction_IF` shows 0, 4, 8, … with `PC_Plus_4_IF` 4, 8, 12, …, one per cycle from the 2nd edge.
- Stall for 5 cycles with 2 words queued: `Imem_Req` drops and outputs stay constant. After release, words 0 and 4 are consumed in order with no loss or duplicate.
- `Branch_Taken_ID` = 1, target `32'h100`, no stall, queue holding 2 words: bubble this cycle, queue flushed, next `Imem_Addr` = `32'h100`.
- Jump to `32'h200` and branch to `32'h300` in the same cycle: the fetch goes to `32'h200`.
- Redirect while BUSY with `Imem_Ready` low for 3 cycles: the state passes through SQUASH, the stale word is never output, and the target is fetched after `Imem_Ready`.
- Redirect asserted together with stall = 1: ignored, and PC is unchanged.
